hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for a five-stage in-order core.
// Generates per-stage stall/flush controls, ALU operand forwarding selects,
// and sequences multi-cycle multiply/divide and data-memory waits.
// Optional feature: define HAZARD_FORWARDING_EN to enable operand forwarding;
// without it, every decode-stage RAW dependency on E/M is resolved by stalling.
module hazard_controller #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] e_rs,
  input  logic [4:0] e_rt,
  input  logic [4:0] e_rf_wa,
  input  logic       e_rf_we,
  input  logic       e_is_load,
  input  logic [4:0] m_rf_wa,
  input  logic       m_rf_we,
  input  logic [4:0] w_rf_wa,
  input  logic       w_rf_we,
  input  logic       e_branch_taken,
  input  logic       e_muldiv_start,
  input  logic       m_dmem_access,
  input  logic       dmem_ready,
  output logic       f_stall,
  output logic       d_stall,
  output logic       e_stall,
  output logic       m_stall,
  output logic       d_flush,
  output logic       e_flush,
  output logic       m_flush,
  output logic       w_flush,
  output logic [1:0] e_fwd_a,
  output logic [1:0] e_fwd_b,
  output logic       muldiv_busy
);

  typedef enum logic [1:0] {StRun, StMuldiv, StMemwait} state_e;

  localparam logic [7:0] CntLoad = 8'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic mem_wait;
  logic load_use;
  logic data_stall;

  assign mem_wait = m_dmem_access && !dmem_ready;
  assign load_use = e_is_load && (e_rf_wa != 5'd0) && ((e_rf_wa == d_rs) || (e_rf_wa == d_rt));

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fwd_a, fwd_b;
  logic       unused_raw;

  // Only loads need a stall; every other dependency is covered by forwarding.
  assign data_stall = load_use;
  assign unused_raw = e_rf_we;

  // Operand source select; memory stage holds the younger result so it wins.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (m_rf_we && (m_rf_wa != 5'd0) && (m_rf_wa == e_rs)) begin
      fwd_a = 2'b10;
    end else if (w_rf_we && (w_rf_wa != 5'd0) && (w_rf_wa == e_rs)) begin
      fwd_a = 2'b01;
    end
    if (m_rf_we && (m_rf_wa != 5'd0) && (m_rf_wa == e_rt)) begin
      fwd_b = 2'b10;
    end else if (w_rf_we && (w_rf_wa != 5'd0) && (w_rf_wa == e_rt)) begin
      fwd_b = 2'b01;
    end
  end
`else
  logic fwd_none_e_hit;
  logic fwd_none_m_hit;
  logic unused_fwd;

  // Without forwarding, decode waits until producers in E and M have retired
  // past the register file (writeback writes in the first half-cycle).
  assign fwd_none_e_hit = e_rf_we && (e_rf_wa != 5'd0) &&
                          ((e_rf_wa == d_rs) || (e_rf_wa == d_rt));
  assign fwd_none_m_hit = m_rf_we && (m_rf_wa != 5'd0) &&
                          ((m_rf_wa == d_rs) || (m_rf_wa == d_rt));
  assign data_stall     = load_use || fwd_none_e_hit || fwd_none_m_hit;
  assign unused_fwd     = ^{e_rs, e_rt, w_rf_wa, w_rf_we};
`endif

  // State and occupancy counter; reset abandons any multi-cycle operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall/flush decode; all outputs forced low during reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    e_stall     = 1'b0;
    m_stall     = 1'b0;
    d_flush     = 1'b0;
    e_flush     = 1'b0;
    m_flush     = 1'b0;
    w_flush     = 1'b0;
    muldiv_busy = 1'b0;
    e_fwd_a     = 2'b00;
    e_fwd_b     = 2'b00;

    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          // Memory wait outranks everything; branch/muldiv stay held in E.
          {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
          w_flush = 1'b1;
          state_d = StMemwait;
        end else if (e_branch_taken) begin
          d_flush = 1'b1;
          e_flush = 1'b1;
        end else if (data_stall) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          e_flush = 1'b1;
        end else if (e_muldiv_start) begin
          // Entry cycle is the first of MULDIV_CYCLES stall cycles.
          {f_stall, d_stall, e_stall} = 3'b111;
          m_flush     = 1'b1;
          muldiv_busy = 1'b1;
          cnt_d       = CntLoad;
          state_d     = StMuldiv;
        end
      end
      StMuldiv: begin
        if (cnt_q == 8'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 8'd1;
          {f_stall, d_stall, e_stall} = 3'b111;
          m_flush     = 1'b1;
          muldiv_busy = 1'b1;
        end
      end
      StMemwait: begin
        if (!dmem_ready) begin
          {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
          w_flush = 1'b1;
        end else begin
          // Pipeline advances this cycle, so a held taken branch resolves now.
          state_d = StRun;
          if (e_branch_taken) begin
            d_flush = 1'b1;
            e_flush = 1'b1;
          end
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 8'd0;
      end
    endcase

`ifdef HAZARD_FORWARDING_EN
    e_fwd_a = fwd_a;
    e_fwd_b = fwd_b;
`endif

    if (!reset_n) begin
      f_stall     = 1'b0;
      d_stall     = 1'b0;
      e_stall     = 1'b0;
      m_stall     = 1'b0;
      d_flush     = 1'b0;
      e_flush     = 1'b0;
      m_flush     = 1'b0;
      w_flush     = 1'b0;
      muldiv_busy = 1'b0;
      e_fwd_a     = 2'b00;
      e_fwd_b     = 2'b00;
    end
  end

endmodule
